// File: rtl/tc_hdd_pkg.sv
// -----------------------------------------------------------------------------
// tc_hdd_pkg
//   Shared definitions for the Hdd drive-port master:
//     - default widths for data words, drive pointer and command length
//     - FSM state encoding (3-bit, legacy-compatible constants)
// -----------------------------------------------------------------------------
package tc_hdd_pkg;

    // Default widths
    localparam int HDD_DATA_W = 64;  // drive word width
    localparam int HDD_ADDR_W = 64;  // drive pointer / seek width
    localparam int HDD_LEN_W  = 16;  // command length width (words)

    // State enum: IDLE, SEEK, RD, WR, DRAIN, DONE
    typedef logic [2:0] hdd_state_t;

    localparam hdd_state_t ST_IDLE  = 3'd0;
    localparam hdd_state_t ST_SEEK  = 3'd1;
    localparam hdd_state_t ST_RD    = 3'd2;
    localparam hdd_state_t ST_WR    = 3'd3;
    localparam hdd_state_t ST_DRAIN = 3'd4;
    localparam hdd_state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/tc_hdd_skid.sv
// -----------------------------------------------------------------------------
// tc_hdd_skid
//   Two-entry valid/ready buffer for drive read data.
//
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     in_valid      push in_data this cycle (no in_ready: the producer
//                   budgets pushes against `occupancy` so it never overflows)
//     in_data       word to push
//     out_valid     buffer holds at least one word
//     out_ready     consumer accepts the head word
//     out_data      head word (zero after reset)
//     occupancy     number of words held (0..2)
// -----------------------------------------------------------------------------
module tc_hdd_skid
    import tc_hdd_pkg::*;
#(
    parameter int W = HDD_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         pop;
    logic [1:0]   count_after_pop;

    always_comb begin
        pop             = (count_q != 2'd0) && out_ready;
        count_after_pop = count_q - {1'b0, pop};
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_after_pop + {1'b0, in_valid};

        // Popping shifts the tail word up into the head slot.
        if (pop) begin
            head_d = tail_q;
        end

        // A push lands in the first free slot after this cycle's pop.
        if (in_valid) begin
            if (count_after_pop == 2'd0) begin
                head_d = in_data;
            end else begin
                tail_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign occupancy = count_q;

endmodule

// File: rtl/tc_hdd_master.sv
// -----------------------------------------------------------------------------
// tc_hdd_master
//   Initiator for one Hdd drive. Accepts block commands (start address,
//   length, direction), drives the drive's relative seek / load / save pins,
//   streams read data out and write data in. Holds the only mirror (ptr) of
//   the drive's word pointer; drive and master share rst so both start at 0.
//
//   Handshakes (cmd, wr, rd): a word transfers on a rising clk edge where
//   valid and ready are both high. Neither valid nor ready produced here
//   depends combinationally on the partner's signal.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//     cmd_addr, cmd_len        absolute start word, word count (0 legal)
//     cmd_write                1 = write to drive, 0 = read from drive
//     wr_valid/wr_ready/wr_data  write-data stream (ready only in WR)
//     rd_valid/rd_ready/rd_data  read-data stream (head of skid buffer)
//     busy                     high in every state except IDLE
//     done                     one-cycle pulse at command completion
//     hdd_seek                 signed pointer delta applied by the drive
//     hdd_load/hdd_save        drive read / write at the pre-seek pointer
//     hdd_in                   write word to drive
//     hdd_out                  drive read word, valid the cycle after load
//     dbg_state                current FSM state
// -----------------------------------------------------------------------------
module tc_hdd_master
    import tc_hdd_pkg::*;
#(
    parameter int DATA_W = HDD_DATA_W,
    parameter int ADDR_W = HDD_ADDR_W,
    parameter int LEN_W  = HDD_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_write,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] hdd_seek,
    output logic              hdd_load,
    output logic              hdd_save,
    output logic [DATA_W-1:0] hdd_in,
    input  logic [DATA_W-1:0] hdd_out,
    output hdd_state_t        dbg_state
);

    hdd_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              write_q, write_d;
    logic [LEN_W-1:0]  issued_q, issued_d;       // loads issued so far
    logic [LEN_W-1:0]  remaining_q, remaining_d; // words not yet transferred
    logic              inflight_q, inflight_d;   // load issued last cycle

    logic [1:0]        skid_occ;
    logic              rd_pop;
    logic [2:0]        held_after;
    logic              issue_ok;

    assign rd_pop = rd_valid && rd_ready;

    // Words that will still be buffered or in flight after this cycle if no
    // new load is issued. Counting this cycle's pop lets a new load go out in
    // the same cycle a word leaves, which sustains one word per cycle.
    assign held_after = {1'b0, skid_occ} + {2'b00, inflight_q} - {2'b00, rd_pop};
    assign issue_ok   = (issued_q != len_q) && (held_after < 3'd2);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        write_d     = write_q;
        issued_d    = issued_q;
        remaining_d = remaining_q;
        inflight_d  = 1'b0;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        done        = 1'b0;
        hdd_seek    = '0;
        hdd_load    = 1'b0;
        hdd_save    = 1'b0;
        hdd_in      = '0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    len_d       = cmd_len;
                    write_d     = cmd_write;
                    issued_d    = '0;
                    remaining_d = cmd_len;
                    state_d     = (cmd_len == '0) ? ST_DONE : ST_SEEK;
                end
            end

            ST_SEEK: begin
                // Relative jump from the mirrored pointer; wraps naturally.
                hdd_seek = addr_q - ptr_q;
                state_d  = write_q ? ST_WR : ST_RD;
            end

            ST_RD: begin
                if (issue_ok) begin
                    hdd_load   = 1'b1;
                    hdd_seek   = ADDR_W'(1);
                    inflight_d = 1'b1;
                    issued_d   = issued_q + LEN_W'(1);
                    if (issued_d == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
                if (rd_pop) begin
                    remaining_d = remaining_q - LEN_W'(1);
                end
            end

            ST_DRAIN: begin
                // The last outstanding word leaving means buffer and
                // pipeline are both empty from the next cycle on.
                if (rd_pop) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_WR: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    hdd_save    = 1'b1;
                    hdd_in      = wr_data;
                    hdd_seek    = ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The drive applies the same delta on the same edge.
        ptr_d = ptr_q + hdd_seek;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            ptr_q       <= '0;
            len_q       <= '0;
            write_q     <= 1'b0;
            issued_q    <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            write_q     <= write_d;
            issued_q    <= issued_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
        end
    end

    // hdd_out is valid exactly one cycle after a load.
    tc_hdd_skid #(
        .W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight_q),
        .in_data   (hdd_out),
        .out_valid (rd_valid),
        .out_ready (rd_ready),
        .out_data  (rd_data),
        .occupancy (skid_occ)
    );

    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tc_hdd_master.sv
// -----------------------------------------------------------------------------
// tb_tc_hdd_master
//   Directed bench for tc_hdd_master with a behavioural Hdd drive model and a
//   read-data scoreboard (expected words queued when a read is commanded,
//   popped on every rd handshake).
// -----------------------------------------------------------------------------
module tb_tc_hdd_master;
    import tc_hdd_pkg::*;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int LW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT ----------------
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          busy, done;
    logic [AW-1:0] hdd_seek;
    logic          hdd_load, hdd_save;
    logic [DW-1:0] hdd_in;
    logic [DW-1:0] hdd_out;
    hdd_state_t    dbg_state;

    tc_hdd_master #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .LEN_W  (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_write (cmd_write),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .hdd_seek  (hdd_seek),
        .hdd_load  (hdd_load),
        .hdd_save  (hdd_save),
        .hdd_in    (hdd_in),
        .hdd_out   (hdd_out),
        .dbg_state (dbg_state)
    );

    // ---------------- memory contents ----------------
    // Unwritten words hold a fixed pattern; words 10..13 hold A0..A3.
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a >= 64'd10 && a <= 64'd13) return 64'hA0 + (a - 64'd10);
        return 64'hD0D0_0000_0000_0000 | a;
    endfunction

    // Drive model: pointer follows hdd_seek every clk; load/save use the
    // pre-seek pointer; hdd_out is registered.
    logic [AW-1:0] drv_ptr;
    logic [DW-1:0] drv_wr [int];

    function automatic logic [DW-1:0] drv_word(input logic [AW-1:0] a);
        if (drv_wr.exists(int'(a[31:0]))) return drv_wr[int'(a[31:0])];
        return init_word(a);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            drv_ptr <= '0;
        end else begin
            if (hdd_load) hdd_out <= drv_word(drv_ptr);
            if (hdd_save) drv_wr[int'(drv_ptr[31:0])] = hdd_in;
            drv_ptr <= drv_ptr + hdd_seek;
        end
    end

    // Bench-side record of what was written, kept from the stimulus only.
    logic [DW-1:0] ref_wr [int];

    function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] a);
        if (ref_wr.exists(int'(a[31:0]))) return ref_wr[int'(a[31:0])];
        return init_word(a);
    endfunction

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int outstanding = 0;
    int max_out = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Read-data monitor and occupancy tracker, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
        end else begin
            if (hdd_load) outstanding++;
            if (rd_valid && rd_ready) outstanding--;
            if (outstanding > max_out) max_out = outstanding;
        end
        if (rd_valid && rd_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL rd_unexpected observed=%h expected=no word", rd_data);
            end
            if (exp_q.size() > 0) chk("rd_data", rd_data, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; checks run at negedge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [AW-1:0] a, input logic [LW-1:0] n, input logic w);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = n;
        cmd_write = w;
        if (!w) begin
            for (int i = 0; i < int'(n); i++) exp_q.push_back(ref_word(a + 64'(i)));
        end
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            cyc();
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk1(tag, seen, 1'b1);
    endtask

    task automatic chk_reset(input string p);
        chk1({p, "_cmd_ready"}, cmd_ready, 1'b1);
        chk1({p, "_busy"},      busy,      1'b0);
        chk1({p, "_done"},      done,      1'b0);
        chk1({p, "_rd_valid"},  rd_valid,  1'b0);
        chk1({p, "_wr_ready"},  wr_ready,  1'b0);
        chk ({p, "_rd_data"},   rd_data,   64'd0);
        chk ({p, "_hdd_seek"},  hdd_seek,  64'd0);
        chk1({p, "_hdd_load"},  hdd_load,  1'b0);
        chk1({p, "_hdd_save"},  hdd_save,  1'b0);
        chk ({p, "_hdd_in"},    hdd_in,    64'd0);
        chk ({p, "_state"},     64'(dbg_state), 64'(ST_IDLE));
    endtask

    logic [3:0]    wr_pat;
    logic [DW-1:0] wword;
    int            wk;

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_write = 1'b0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk_reset("rst_hold");
        cyc(); rst = 1'b0; rd_ready = 1'b1;
        @(negedge clk);
        chk_reset("rst_release");

        // Read addr=10 len=4, rd_ready held high.
        cyc(); start_cmd(64'd10, 16'd4, 1'b0);                      // T
        @(negedge clk); chk1("t1_cmd_ready", cmd_ready, 1'b1);
        cyc(); cmd_valid = 1'b0;                                    // T+1
        @(negedge clk);
        chk("t1_seek_delta", hdd_seek, 64'd10);
        chk1("t1_seek_busy", busy, 1'b1);
        chk1("t1_seek_no_load", hdd_load, 1'b0);
        for (int i = 0; i < 4; i++) begin                           // T+2..T+5
            cyc(); @(negedge clk);
            chk1("t1_load", hdd_load, 1'b1);
            chk("t1_load_seek", hdd_seek, 64'd1);
            chk1("t1_rd_valid", rd_valid, (i >= 2));
        end
        cyc(); @(negedge clk);                                      // T+6
        chk1("t1_no_load", hdd_load, 1'b0);
        chk("t1_drain", 64'(dbg_state), 64'(ST_DRAIN));
        chk1("t1_rd_valid_t6", rd_valid, 1'b1);
        cyc(); @(negedge clk);                                      // T+7
        chk1("t1_done_early", done, 1'b0);
        chk1("t1_rd_valid_t7", rd_valid, 1'b1);
        cyc(); @(negedge clk);                                      // T+8
        chk1("t1_done", done, 1'b1);
        chk1("t1_done_cmd_ready", cmd_ready, 1'b0);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
        cyc(); @(negedge clk);                                      // T+9
        chk1("t1_idle_ready", cmd_ready, 1'b1);
        chk1("t1_idle_busy", busy, 1'b0);

        // Follow-up read at addr=5: backward seek from ptr=14.
        cyc(); start_cmd(64'd5, 16'd2, 1'b0);
        @(negedge clk);
        cyc(); cmd_valid = 1'b0;
        @(negedge clk);
        chk("t2_seek_back", hdd_seek, 64'hFFFF_FFFF_FFFF_FFF7);
        wait_done("t2_done", 20);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // Write addr=0 len=3 with wr_valid pattern 1,0,1,1.
        wr_pat = 4'b1101;
        wk = 0;
        cyc(); wr_valid = 1'b1; wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
        start_cmd(64'd0, 16'd3, 1'b1);
        @(negedge clk);
        chk1("t3_idle_wr_ignored", hdd_save, 1'b0);
        chk1("t3_idle_wr_ready", wr_ready, 1'b0);
        cyc(); cmd_valid = 1'b0;
        @(negedge clk);
        chk1("t3_seek_no_save", hdd_save, 1'b0);
        chk1("t3_seek_wr_ready", wr_ready, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cyc();
            wr_valid = wr_pat[c];
            if (wr_pat[c]) begin
                wword = {$urandom(), $urandom()};
                wr_data = wword;
                ref_wr[wk] = wword;
                wk++;
            end else begin
                wword = '0;
                wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            @(negedge clk);
            chk1("t3_wr_ready", wr_ready, 1'b1);
            chk1("t3_save", hdd_save, wr_pat[c]);
            chk("t3_save_seek", hdd_seek, wr_pat[c] ? 64'd1 : 64'd0);
            chk("t3_hdd_in", hdd_in, wword);
        end
        cyc(); wr_valid = 1'b0;
        @(negedge clk);
        chk1("t3_done", done, 1'b1);
        chk1("t3_done_no_save", hdd_save, 1'b0);
        // Readback of the written words.
        cyc(); start_cmd(64'd0, 16'd3, 1'b0);
        @(negedge clk);
        cyc(); cmd_valid = 1'b0;
        @(negedge clk);
        chk("t3_rb_seek", hdd_seek, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_done("t3_rb_done", 20);
        chk("t3_rb_queue_empty", 64'(exp_q.size()), 64'd0);

        // Read addr=20 len=6 with rd_ready low for 5 cycles mid-burst.
        cyc(); start_cmd(64'd20, 16'd6, 1'b0);
        @(negedge clk);
        cyc(); cmd_valid = 1'b0;
        repeat (3) cyc();
        for (int i = 0; i < 5; i++) begin
            cyc(); rd_ready = 1'b0;
            @(negedge clk);
            chk1("t4_stall_no_load", hdd_load, 1'b0);
            chk1("t4_stall_rd_valid", rd_valid, 1'b1);
        end
        cyc(); rd_ready = 1'b1;
        @(negedge clk);
        wait_done("t4_done", 30);
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t4_max_outstanding", 64'(max_out), 64'd2);

        // len=0: no drive activity, done at T+1, ready again at T+2.
        cyc(); start_cmd(64'd99, 16'd0, 1'b0);
        @(negedge clk);
        chk1("t5_cmd_ready", cmd_ready, 1'b1);
        cyc(); cmd_valid = 1'b0;
        @(negedge clk);
        chk1("t5_done", done, 1'b1);
        chk("t5_no_seek", hdd_seek, 64'd0);
        chk1("t5_no_load", hdd_load, 1'b0);
        chk1("t5_no_save", hdd_save, 1'b0);
        chk1("t5_done_cmd_ready", cmd_ready, 1'b0);
        cyc(); @(negedge clk);
        chk1("t5_ready_again", cmd_ready, 1'b1);
        chk1("t5_done_cleared", done, 1'b0);
        // ptr must still be 26: seek to 20 is -6.
        cyc(); start_cmd(64'd20, 16'd1, 1'b0);
        @(negedge clk);
        cyc(); cmd_valid = 1'b0;
        @(negedge clk);
        chk("t5_ptr_unchanged", hdd_seek, 64'hFFFF_FFFF_FFFF_FFFA);
        wait_done("t5_len1_done", 20);
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a read burst.
        cyc(); start_cmd(64'd40, 16'd8, 1'b0);                      // T
        @(negedge clk);
        cyc(); cmd_valid = 1'b0;                                    // T+1
        repeat (2) cyc();                                           // T+2, T+3
        cyc(); rst = 1'b1;                                          // T+4
        @(negedge clk);
        chk("t6_in_rd", 64'(dbg_state), 64'(ST_RD));
        cyc(); rst = 1'b0;                                          // T+5
        exp_q.delete();
        @(negedge clk);
        chk_reset("t6_after_rst");
        for (int i = 0; i < 3; i++) begin
            cyc(); @(negedge clk);
            chk1("t6_no_done", done, 1'b0);
            chk1("t6_idle", busy, 1'b0);
        end
        // Pointer is back at 0: seek to 3 is +3.
        cyc(); start_cmd(64'd3, 16'd1, 1'b0);
        @(negedge clk);
        cyc(); cmd_valid = 1'b0;
        @(negedge clk);
        chk("t6_ptr_zero", hdd_seek, 64'd3);
        wait_done("t6_post_done", 20);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
